// File: rtl/md_cell_pkg.sv
// Shared constants and types for the cell position RAM read path.
// Word layout is {posz, posy, posx}, 32 bits per axis.
package md_cell_pkg;

   localparam int DATA_WIDTH   = 96;
   localparam int ADDR_WIDTH   = 8;
   localparam int PARTICLE_NUM = 220;

   localparam int POS_W    = 32;
   localparam int POSX_LSB = 0;
   localparam int POSY_LSB = 32;
   localparam int POSZ_LSB = 64;

   typedef enum logic [2:0] {
      IDLE,
      RD_CNT,
      WAIT_CNT,
      STREAM,
      DRAIN,
      DONE
   } state_e;

   function automatic logic [POS_W-1:0] pos_field(
      input logic [DATA_WIDTH-1:0] word,
      input int                    lsb
   );
      return word[lsb +: POS_W];
   endfunction

endpackage

// File: rtl/cell_pos_skid_fifo.sv
// First-word fall-through skid FIFO; the head entry is always visible on dout_o.
// Simultaneous push and pop is accepted in every occupancy, including full.
module cell_pos_skid_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 104
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q;
   logic [AW:0]      rptr_q;
   logic             wr_en;
   logic             rd_en;

   assign count_o = wptr_q - rptr_q;
   assign empty_o = (count_o == '0);
   assign full_o  = (count_o == (AW+1)'(DEPTH));
   assign rd_en   = pop_i && !empty_o;
   assign wr_en   = push_i && (!full_o || rd_en);
   assign dout_o  = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + ONE;
         if (rd_en) rptr_q <= rptr_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/cell_pos_streamer.sv
// Reads the particle count at address 0, then streams words 1..N downstream.
// Reads are throttled so FIFO contents plus reads in flight never exceed the FIFO.
module cell_pos_streamer
   import md_cell_pkg::*;
#(
   parameter int DATA_WIDTH   = md_cell_pkg::DATA_WIDTH,
   parameter int PARTICLE_NUM = md_cell_pkg::PARTICLE_NUM,
   parameter int ADDR_WIDTH   = md_cell_pkg::ADDR_WIDTH,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] particle_count,
   output logic [ADDR_WIDTH-1:0] cell_address,
   output logic                  cell_rden,
   output logic                  cell_wren,
   input  logic [DATA_WIDTH-1:0] cell_q,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_pos,
   output logic [ADDR_WIDTH-1:0] out_pid,
   output logic                  out_last
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = DATA_WIDTH + ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] TWO_A   = ADDR_WIDTH'(2);

   state_e                state_q;
   logic                  wait_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  rden_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] next_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [ADDR_WIDTH-1:0] pid0_q;
   logic [ADDR_WIDTH-1:0] pid1_q;
   logic [1:0]            sr_q;

   logic [ADDR_WIDTH-1:0] raw_cnt;
   logic [ADDR_WIDTH-1:0] cnt_c;
   logic [EW-1:0]         head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CW-1:0]         fifo_cnt;
   logic [CW:0]           occ_c;
   logic                  pop_c;
   logic                  room_c;
   logic                  last_c;

   assign raw_cnt = cell_q[ADDR_WIDTH-1:0];
   assign cnt_c   = (raw_cnt > MAX_CNT) ? MAX_CNT : raw_cnt;
   assign pop_c   = !fifo_empty && out_ready;
   assign last_c  = !fifo_empty && (head[EW-1:DATA_WIDTH] == cnt_q);

   // Slots the next read would compete for, crediting this cycle's pop.
   assign occ_c = (CW+1)'(fifo_cnt)
                + (CW+1)'(rden_q)
                + (CW+1)'(sr_q[0])
                + (CW+1)'(sr_q[1])
                - (CW+1)'(pop_c);
   assign room_c = (occ_c < (CW+1)'(FIFO_DEPTH)) && !fifo_full;

   cell_pos_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (sr_q[1]),
      .din_i   ({pid1_q, cell_q}),
      .pop_i   (pop_c),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wait_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rden_q  <= 1'b0;
         addr_q  <= '0;
         next_q  <= '0;
         cnt_q   <= '0;
         pid0_q  <= '0;
         pid1_q  <= '0;
         sr_q    <= '0;
      end else begin
         rden_q <= 1'b0;
         done_q <= 1'b0;
         sr_q   <= {sr_q[0],
                    rden_q && (state_q == STREAM || state_q == DRAIN)};
         pid0_q <= addr_q;
         pid1_q <= pid0_q;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RD_CNT;
                  rden_q  <= 1'b1;
                  addr_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            RD_CNT: begin
               state_q <= WAIT_CNT;
               wait_q  <= 1'b0;
            end
            WAIT_CNT: begin
               if (!wait_q) begin
                  wait_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_c;
                  if (cnt_c == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     rden_q  <= 1'b1;
                     addr_q  <= ONE_A;
                     next_q  <= TWO_A;
                     state_q <= (cnt_c == ONE_A) ? DRAIN : STREAM;
                  end
               end
            end
            STREAM: begin
               if (room_c) begin
                  rden_q <= 1'b1;
                  addr_q <= next_q;
                  if (next_q == cnt_q) state_q <= DRAIN;
                  else                 next_q  <= next_q + ONE_A;
               end
            end
            DRAIN: begin
               if (pop_c && last_c && sr_q == 2'b00 && !rden_q) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign particle_count = cnt_q;
   assign cell_address   = addr_q;
   assign cell_rden      = rden_q;
   assign cell_wren      = 1'b0;
   assign out_valid      = !fifo_empty;
   assign out_pos        = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
   assign out_pid        = fifo_empty ? '0 : head[EW-1:DATA_WIDTH];
   assign out_last       = last_c;

endmodule

// File: tb/tb_cell_pos_streamer.sv
// Directed bench: 2-cycle RAM model, per-cycle timing, backpressure,
// clamping, mid-stream reset and start-while-busy.
module tb_cell_pos_streamer;

   localparam int DW = 96;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic [AW-1:0] particle_count;
   logic [AW-1:0] cell_address;
   logic          cell_rden;
   logic          cell_wren;
   logic [DW-1:0] cell_q;
   logic [DW-1:0] ram_s1;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_pos;
   logic [AW-1:0] out_pid;
   logic          out_last;

   logic [DW-1:0] mem [0:255];
   int            n_assert = 0;
   int            n_fail   = 0;

   always #5 clk = ~clk;

   cell_pos_streamer dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .particle_count (particle_count),
      .cell_address   (cell_address),
      .cell_rden      (cell_rden),
      .cell_wren      (cell_wren),
      .cell_q         (cell_q),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pos        (out_pos),
      .out_pid        (out_pid),
      .out_last       (out_last)
   );

   // RAM: data for the read issued in cycle c is on cell_q during c+2
   always @(posedge clk) begin
      ram_s1 <= cell_rden ? mem[cell_address] : {3{32'hBAD0_BAD0}};
      cell_q <= ram_s1;
   end

   function automatic logic [DW-1:0] pos_of(input int seed, input int a);
      logic [31:0] s;
      s = 32'(seed + a);
      return {s + 32'h3000_0000, s + 32'h2000_0000, s + 32'h1000_0000};
   endfunction

   task automatic chk(input string tag,
                      input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] c, input int seed);
      mem[0] = {64'hFFFF_0000_1234_5678, 24'h5A5A5A, c};
      for (int a = 1; a < 256; a++) mem[a] = pos_of(seed, a);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_stream(input logic [7:0] raw, input int expn,
                             input int seed, input int stall_at,
                             input int stall_len, input int dup_at,
                             output int k_done);
      int nxt, outst, maxo, last_rd, k;
      nxt = 1; outst = 0; maxo = 0; last_rd = 0; k = 1;
      load(raw, seed);
      pulse_start();
      while (k < 2000) begin
         if (done) break;
         out_ready = !(k >= stall_at && k < stall_at + stall_len);
         start = (k == dup_at);
         chk("busy_during", busy, 1);
         if (cell_rden && cell_address != 0) begin
            outst++;
            last_rd = cell_address;
         end
         if (outst > maxo) maxo = outst;
         if (out_valid && out_ready) begin
            chk("pid", out_pid, nxt);
            chk("pos", out_pos, pos_of(seed, nxt));
            chk("last", out_last, nxt == expn);
            nxt++;
            outst--;
         end
         tick();
         k++;
      end
      start = 1'b0;
      out_ready = 1'b1;
      k_done = k;
      chk("done_seen", done, 1);
      chk("busy_at_done", busy, 0);
      chk("count", particle_count, expn);
      chk("delivered", nxt - 1, expn);
      chk("last_rd_addr", last_rd, expn);
      chk("max_outstanding_le4", maxo <= 4, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_done", done, 0);
         chk("post_busy", busy, 0);
         chk("post_valid", out_valid, 0);
         chk("post_rden", cell_rden, 0);
      end
   endtask

   initial begin
      int kd;
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      load(8'd0, 0);
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rden", cell_rden, 0);
      chk("rst_wren", cell_wren, 0);
      chk("rst_addr", cell_address, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_count", particle_count, 0);
      rst = 1'b0;
      tick();

      // addr0=3: per-cycle timing relative to start cycle T
      load(8'd3, 100);
      pulse_start();
      for (int k = 1; k <= 11; k++) begin
         chk($sformatf("t3_busy_k%0d", k), busy, k <= 9);
         chk($sformatf("t3_done_k%0d", k), done, k == 10);
         chk($sformatf("t3_valid_k%0d", k), out_valid, k >= 7 && k <= 9);
         chk($sformatf("t3_last_k%0d", k), out_last, k == 9);
         chk($sformatf("t3_rden_k%0d", k), cell_rden,
             k == 1 || (k >= 4 && k <= 6));
         if (k == 1) chk("t3_addr_cnt", cell_address, 0);
         if (k >= 4 && k <= 6)
            chk($sformatf("t3_addr_k%0d", k), cell_address, k - 3);
         if (k >= 7 && k <= 9) begin
            chk($sformatf("t3_pid_k%0d", k), out_pid, k - 6);
            chk($sformatf("t3_pos_k%0d", k), out_pos, pos_of(100, k - 6));
         end
         tick();
      end
      chk("t3_count", particle_count, 3);

      // addr0=0: only the count read, done at T+4
      run_stream(8'd0, 0, 200, 0, 0, 0, kd);
      chk("t0_done_cycle", kd, 4);

      // addr0=20 with 12 cycles of backpressure mid-stream
      run_stream(8'd20, 20, 300, 12, 12, 0, kd);

      // addr0=255 clamps to 219
      run_stream(8'd255, 219, 400, 0, 0, 0, kd);
      chk("t255_done_cycle", kd, 226);

      // reset while pid 5 of 10 is pending
      load(8'd10, 77);
      pulse_start();
      for (int i = 0; i < 50; i++) begin
         if (out_valid && out_pid == 5) break;
         tick();
      end
      chk("rst_mid_pid5", out_pid, 5);
      rst = 1'b1;
      tick();
      chk("rm_busy", busy, 0);
      chk("rm_done", done, 0);
      chk("rm_valid", out_valid, 0);
      chk("rm_rden", cell_rden, 0);
      chk("rm_addr", cell_address, 0);
      chk("rm_count", particle_count, 0);
      chk("rm_pid", out_pid, 0);
      chk("rm_pos", out_pos, 0);
      chk("rm_last", out_last, 0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rm_stale_valid", out_valid, 0);
         chk("rm_stale_busy", busy, 0);
      end
      run_stream(8'd10, 10, 91, 0, 0, 0, kd);
      chk("t10_done_cycle", kd, 17);

      // start pulsed while busy is ignored
      run_stream(8'd6, 6, 500, 0, 0, 5, kd);
      chk("dup_done_cycle", kd, 13);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cell_pos_streamer.md
Name: cell_pos_streamer

Overview:
- Read-side controller for one per-cell position RAM (cell_x_y_z family). Single-port, 2-cycle read latency; address 0 holds the particle count, addresses 1..N hold {posz, posy, posx}.
- On a start pulse it reads the count, then streams every particle word in address order to the downstream force/motion pipeline over a valid/ready handshake.
- An internal skid FIFO absorbs RAM latency, so backpressure never loses or reorders data.

Parameters:
- DATA_WIDTH, 96, width of one RAM word ({posz,posy,posx}, 32 bits each).
- PARTICLE_NUM, 220, RAM depth in words (address 0 included).
- ADDR_WIDTH, 8, RAM address width.
- FIFO_DEPTH, 4, skid FIFO entries; power of two, minimum 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to stream the cell; ignored unless IDLE
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses
- done  out  1  one-cycle pulse after the last particle is accepted downstream, or after count==0 is read
- particle_count  out  ADDR_WIDTH  clamped count captured from address 0; holds until next start
- cell_address  out  ADDR_WIDTH  RAM address, registered
- cell_rden  out  1  RAM read enable, registered
- cell_wren  out  1  constant 0; this block never writes
- cell_q  in  DATA_WIDTH  RAM read data, valid 2 cycles after the cycle cell_rden is high
- out_valid  out  1  out_pos, out_pid and out_last are valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_pos  out  DATA_WIDTH  particle position word
- out_pid  out  ADDR_WIDTH  RAM address of the word (1..N)
- out_last  out  1  high with the final particle of the cell

Behaviour:
- Reset values:
  - All outputs 0 (cell_address=0, cell_rden=0, out_valid=0, busy=0, done=0, particle_count=0).
  - FSM returns to IDLE; FIFO is emptied; the in-flight tracking shift register is cleared.
  - RAM data already in flight is discarded. Reset mid-stream is clean; the next start behaves as from power-up.
- FSM states and transitions:
  - IDLE: start=1 -> RD_CNT.
  - RD_CNT: cell_rden=1, cell_address=0 for exactly one cycle -> WAIT_CNT.
  - WAIT_CNT: waits 2 cycles, then captures cnt = cell_q[ADDR_WIDTH-1:0].
    - cnt is clamped to PARTICLE_NUM-1 if larger.
    - cnt==0 -> DONE; otherwise -> STREAM with next_addr=1.
  - STREAM: issues one read per cycle (cell_rden=1, cell_address=next_addr, next_addr++) only while (FIFO occupancy + reads in flight) < FIFO_DEPTH.
    - After the read of address cnt is issued -> DRAIN.
  - DRAIN: waits until in-flight reads are 0 and the last word has been popped -> DONE.
  - DONE: done=1 for one cycle, busy falls -> IDLE.
- Latency:
  - start sampled high at cycle T: RD_CNT at T+1, count on cell_q at T+3.
  - First data read issued at T+4; first out_valid at T+7 (2-cycle RAM delay plus one FIFO write cycle).
  - With out_ready held high, throughput is one particle per cycle.
- In-flight tracking: 2-bit valid shift register aligned with RAM latency. An entry exiting the register pushes cell_q and its pid into the FIFO in the same cycle.
- FIFO:
  - First-word fall-through; out_* driven directly from the head entry.
  - Push and pop in the same cycle is legal, including when full or empty-with-push.
  - Push while full cannot occur by construction; the bench asserts this.
- out_last = head pid == particle_count.
- done asserts the cycle after the out_last handshake.
- start while busy: ignored, no state change.
- out_valid, once high, holds with stable payload until accepted.
- next_addr is ADDR_WIDTH bits and never exceeds PARTICLE_NUM-1, so it cannot wrap.

Decomposition:
- Shared package md_cell_pkg:
  - Width constants (DATA_WIDTH, ADDR_WIDTH, PARTICLE_NUM).
  - FSM state enum (IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE).
  - Position word field offsets (posx [31:0], posy [63:32], posz [95:64]).
- One sub-module, cell_pos_skid_fifo: parameterised FIFO_DEPTH x (DATA_WIDTH+ADDR_WIDTH), FWFT, full/empty/count outputs.

Test Plan:
- RAM model with 2-cycle latency, addr0=3, out_ready=1, start at T:
  - pids 1,2,3 on consecutive cycles from T+7; out_last only with pid 3.
  - done at T+10; busy high T+1..T+9.
- addr0=0:
  - rden seen only for address 0; out_valid never high.
  - done pulses at T+4.
- addr0=20, out_ready low for 12 cycles mid-stream:
  - Reads outstanding plus FIFO occupancy never exceeds 4.
  - All pids 1..20 delivered once, in order, with payloads matching the model.
- addr0=255: particle_count=219; last address read is 219; out_last with pid 219.
- rst asserted for 1 cycle while pid 5 of 10 is pending:
  - All outputs 0 next cycle; stale RAM returns not emitted.
  - A fresh start streams pids 1..10 correctly.
- start pulsed again while busy: ignored; the stream completes unchanged with a single done.
